// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for both ends of the cache controller downstream path.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// The cache controller FSM and the memory-side responder both import this
// package, so they agree on the header word format and the state encoding.
package cache_ctrl_pkg;

    // Responder command states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_DATA = 3'd1,
        WB_MEM  = 3'd2,
        RF_MEM  = 3'd3,
        RF_SEND = 3'd4
    } state_e;

    // Header op bit encoding.
    localparam logic OP_REFILL    = 1'b0;
    localparam logic OP_WRITEBACK = 1'b1;

    // Header layout: bit HDR_OP_BIT carries the op. Bits [OFF-1:1] are don't-care.
    // Bits [ADDR_WIDTH-1:OFF] carry the line-aligned base address.
    localparam int HDR_OP_BIT = 0;

    // Number of byte-offset bits within one cache line (OFF).
    function automatic int line_off(input int data_width, input int line_words);
        return $clog2(line_words * (data_width / 8));
    endfunction

    // Shift that turns a word index into a byte offset.
    function automatic int word_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/cache_mem_resp.sv
// Memory-side responder: pops write-back/refill commands from the request queue and runs word-wise memory accesses.
// Latency: header pop to first mreq_o 1 cycle; zero-wait memory gives 2 cycles per word for both refill and write-back.
// Backpressure: qvld_i low in WB_DATA, a missing mack_i, or rrdy_i low in RF_SEND stalls with all outputs held.
//
// Ports:
//   clk, reset        single clock, asynchronous active-low reset
//   qvld_i/qrdy_o/qdat_i   request queue read side (header word, then data words for write-back)
//   mreq_o/mwe_o/maddr_o/mwdat_o/mack_i/mrdat_i   memory port, request held until mack_i
//   rvld_o/rrdy_i/rdat_o/rlast_o   refill response channel, one word per beat, last word flagged
//   busy_o            a command is in progress
module cache_mem_resp
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,   // must equal DATA_WIDTH: the header word carries the address
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4     // power of two, >= 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  qvld_i,
    output logic                  qrdy_o,
    input  logic [DATA_WIDTH-1:0] qdat_i,

    output logic                  mreq_o,
    output logic                  mwe_o,
    output logic [ADDR_WIDTH-1:0] maddr_o,
    output logic [DATA_WIDTH-1:0] mwdat_o,
    input  logic                  mack_i,
    input  logic [DATA_WIDTH-1:0] mrdat_i,

    output logic                  rvld_o,
    input  logic                  rrdy_i,
    output logic [DATA_WIDTH-1:0] rdat_o,
    output logic                  rlast_o,

    output logic                  busy_o
);

    localparam int OFF   = line_off(DATA_WIDTH, LINE_WORDS);
    localparam int WSH   = word_shift(DATA_WIDTH);
    localparam int CNT_W = $clog2(LINE_WORDS);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = {ADDR_WIDTH{1'b1}} << OFF;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q,  base_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic                    mreq_q,  mreq_d;
    logic                    mwe_q,   mwe_d;
    logic [DATA_WIDTH-1:0]   mwdat_q, mwdat_d;
    logic                    rvld_q,  rvld_d;
    logic                    rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0]   rdat_q,  rdat_d;

    logic qbeat;
    logic rbeat;
    logic mdone;

    // The queue may only pop while waiting for a header or a write-back data
    // word. Gating with reset keeps qrdy_o low while reset is asserted even
    // though the state register already reads IDLE.
    assign qrdy_o = reset & ((state_q == IDLE) || (state_q == WB_DATA));

    assign qbeat = qvld_i & qrdy_o;
    assign rbeat = rvld_q & rrdy_i;
    assign mdone = mreq_q & mack_i;   // mack_i means nothing without a request

    // The base has its low OFF bits cleared and the word offset fits inside
    // them, so OR is an add that can never carry into the base.
    assign maddr_o = base_q | (ADDR_WIDTH'(cnt_q) << WSH);

    assign mreq_o  = mreq_q;
    assign mwe_o   = mwe_q;
    assign mwdat_o = mwdat_q;
    assign rvld_o  = rvld_q;
    assign rlast_o = rlast_q;
    assign rdat_o  = rdat_q;
    assign busy_o  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        mreq_d  = mreq_q;
        mwe_d   = mwe_q;
        mwdat_d = mwdat_q;
        rvld_d  = rvld_q;
        rlast_d = rlast_q;
        rdat_d  = rdat_q;

        case (state_q)
            IDLE: begin
                if (qbeat) begin
                    base_d = qdat_i[ADDR_WIDTH-1:0] & BASE_MASK;
                    cnt_d  = '0;
                    case (qdat_i[HDR_OP_BIT])
                        OP_WRITEBACK: begin
                            state_d = WB_DATA;
                        end
                        OP_REFILL: begin
                            // Refill reads start the cycle after the header pop.
                            state_d = RF_MEM;
                            mreq_d  = 1'b1;
                            mwe_d   = 1'b0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end

            WB_DATA: begin
                if (qbeat) begin
                    mwdat_d = qdat_i;
                    mreq_d  = 1'b1;
                    mwe_d   = 1'b1;
                    state_d = WB_MEM;
                end
            end

            WB_MEM: begin
                if (mdone) begin
                    mreq_d = 1'b0;
                    mwe_d  = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WB_DATA;
                    end
                end
            end

            RF_MEM: begin
                if (mdone) begin
                    rdat_d  = mrdat_i;
                    mreq_d  = 1'b0;
                    rvld_d  = 1'b1;
                    rlast_d = (cnt_q == CNT_LAST);
                    state_d = RF_SEND;
                end
            end

            RF_SEND: begin
                if (rbeat) begin
                    rvld_d  = 1'b0;
                    rlast_d = 1'b0;
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        // Issue the next read immediately so a line streams at
                        // two cycles per word.
                        cnt_d   = cnt_q + 1'b1;
                        mreq_d  = 1'b1;
                        mwe_d   = 1'b0;
                        state_d = RF_MEM;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
                rvld_d  = 1'b0;
                rlast_d = 1'b0;
            end
        endcase
    end

    // Reset aborts any command in flight; nothing of a partial line survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            mwdat_q <= '0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            mwdat_q <= mwdat_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
            rdat_q  <= rdat_d;
        end
    end

endmodule

// File: doc/cache_mem_resp.md
Name: cache_mem_resp

Overview:
- Memory-side responder at the far end of the cache controller's downstream request queue.
- Pops request words (write-back or refill commands) from the async queue read side and performs word-wise accesses on the memory port.
- For refills, returns the line to the cache controller on a response channel, one word per beat, last word flagged.
- Sits between the request queue output and the memory bus adapter.

Parameters:
ADDR_WIDTH, 32, byte address width; must equal DATA_WIDTH (header word carries the address)
DATA_WIDTH, 32, queue, memory and response word width
LINE_WORDS, 4, words per cache line; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
qvld_i  input  1  request queue word valid
qrdy_o  output  1  responder ready to pop a queue word
qdat_i  input  DATA_WIDTH  request queue word
mreq_o  output  1  memory access request, held until mack_i
mwe_o  output  1  memory access is a write
maddr_o  output  ADDR_WIDTH  memory word byte address
mwdat_o  output  DATA_WIDTH  memory write data
mack_i  input  1  memory access complete; mrdat_i valid same cycle on reads
mrdat_i  input  DATA_WIDTH  memory read data
rvld_o  output  1  refill response word valid
rrdy_i  input  1  cache controller accepts response word
rdat_o  output  DATA_WIDTH  refill response word
rlast_o  output  1  final word of line, qualified by rvld_o
busy_o  output  1  command in progress (state != IDLE)

Behaviour:
- Reset: clk and reset are the single clock and its reset; reset is asynchronous, active-low. While reset is low, state=IDLE, all counters 0, qrdy_o=0, mreq_o=0, mwe_o=0, rvld_o=0, rlast_o=0, busy_o=0, maddr_o/mwdat_o/rdat_o=0. Reset mid-command aborts it: no partial line is resumed, and an outstanding mack_i after reset is ignored.
- Beats: qbeat = qvld_i & qrdy_o; rbeat = rvld_o & rrdy_i. mack_i is ignored unless mreq_o=1.
- Header word: bit0 = op (1 = write-back, 0 = refill). The line-aligned base address is the header with its low OFF = log2(LINE_WORDS*DATA_WIDTH/8) bits zeroed. Bits [OFF-1:1] are ignored.
- Word address: base + cnt*(DATA_WIDTH/8). cnt is log2(LINE_WORDS) bits wide and wraps at the end of the line; the carry never propagates into the base.
- States:
  - IDLE: qrdy_o=1. On qbeat, latch base and op, clear cnt. Go to WB_DATA if op=1, else RF_MEM.
  - WB_DATA: qrdy_o=1. On qbeat, register qdat_i into mwdat_o, assert mreq_o=1 and mwe_o=1 next cycle, go to WB_MEM.
  - WB_MEM: qrdy_o=0; mreq_o, mwe_o, maddr_o and mwdat_o are held stable until mack_i. On mack_i, drop mreq_o. If cnt==LINE_WORDS-1, go to IDLE; otherwise cnt++ and go to WB_DATA.
  - RF_MEM: mreq_o=1, mwe_o=0, maddr_o stable. On mack_i, capture mrdat_i into rdat_o, drop mreq_o, set rvld_o=1 and rlast_o=(cnt==LINE_WORDS-1), go to RF_SEND.
  - RF_SEND: rvld_o, rdat_o and rlast_o are held until rbeat. On rbeat, clear rvld_o. If rlast_o, go to IDLE; otherwise cnt++ and go to RF_MEM.
- Latency:
  - Refill: header qbeat in cycle N puts mreq_o high at N+1. With zero-wait mack at N+1, rvld_o rises at N+2. Best case is 2 cycles per word.
  - Write-back: at most one memory write outstanding; best case is 2 cycles per word.
- No overlap of commands: the next header is not popped until the current command returns to IDLE. qrdy_o=0 in RF_MEM, RF_SEND and WB_MEM.
- rvld_o never deasserts without rbeat; mreq_o never deasserts without mack_i (except on reset).
- Back-pressure: qvld_i low in WB_DATA, or rrdy_i low in RF_SEND, stalls indefinitely with outputs stable.

Decomposition:
- Shared package cache_ctrl_pkg holds:
  - state enum (IDLE, WB_DATA, WB_MEM, RF_MEM, RF_SEND);
  - op encoding constants OP_REFILL=0, OP_WRITEBACK=1;
  - header field positions, including a function computing OFF from DATA_WIDTH and LINE_WORDS.
- The same package is imported by the cache controller FSM, so both ends share the header format.
- Single flat module; the address/word-counter generator is small enough to stay inline. No sub-module.

Test Plan:
- Refill, zero-wait: header 0x0000_1000 (op 0), mack_i same cycle as mreq_o, rrdy_i=1, mrdat_i=addr^0xA5A5_A5A5 -> reads at 0x1000/0x1004/0x1008/0x100C in order; 4 response beats with rlast_o only on the 4th; busy_o low the cycle after the last rbeat.
- Write-back: header 0x0000_2001 then data 0x11,0x22,0x33,0x44 -> four writes, mwe_o=1, to 0x2000..0x200C with matching data; qrdy_o=0 while each write is pending.
- Stalls: mack_i delayed 3 cycles and rrdy_i low 5 cycles during a refill -> mreq_o/maddr_o and rvld_o/rdat_o/rlast_o held stable throughout; no word lost or duplicated.
- Header low bits: header 0x0000_300F -> base 0x3000, write-back; ignored bits do not affect addresses.
- Reset mid-refill: assert reset (low) after the second response beat -> all outputs 0 immediately (asynchronously); after release, a new refill header 0x4000 completes normally; a stray mack_i while idle is ignored.
- Back-to-back: refill header presented the same cycle as the last write-back mack_i -> header not popped until IDLE; second command executes correctly.
